// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback stage (A) normally owns the port, and
// long-latency results (B) queue in a small FIFO that drains into idle or starved cycles.
module wb_port_arbiter #(
    parameter int WORD       = 32,
    parameter int W_RD       = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_v_i,
    input  logic                     a_wb_i,
    input  logic [W_RD-1:0]          a_rd_num_i,
    input  logic [WORD-1:0]          a_data_i,
    output logic                     a_stall_o,
    input  logic                     b_v_i,
    output logic                     b_ready_o,
    input  logic [W_RD-1:0]          b_rd_num_i,
    input  logic [WORD-1:0]          b_data_i,
    output logic [$clog2(DEPTH):0]   pend_o,
    output logic                     wb_o,
    output logic [W_RD-1:0]          wbr_num_o,
    output logic [WORD-1:0]          wb_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_MAX);

    logic [W_RD-1:0] rd_mem   [DEPTH];
    logic [WORD-1:0] data_mem [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wb_q, wb_d;
    logic [W_RD-1:0] wbr_num_q, wbr_num_d;
    logic [WORD-1:0] wb_data_q, wb_data_d;

    logic a_req;
    logic not_empty;
    logic push;
    logic store;
    logic pop;
    logic force_drain;

    assign a_req       = a_v_i & a_wb_i & (a_rd_num_i != '0);
    assign not_empty   = (pend_q != '0);
    assign b_ready_o   = (pend_q != FULL_CNT);
    assign push        = b_v_i & b_ready_o;
    // Results aimed at x0 are handshaken but never occupy a slot.
    assign store       = push & (b_rd_num_i != '0);
    assign force_drain = not_empty & (cnt_q == CNT_MAX);
    assign pop         = force_drain | (~a_req & not_empty);
    assign a_stall_o   = force_drain & a_v_i;

    assign pend_o    = pend_q;
    assign wb_o      = wb_q;
    assign wbr_num_o = wbr_num_q;
    assign wb_data_o = wb_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (store && (wr_ptr_q == PW'(gi))) begin
                    rd_mem[gi]   <= b_rd_num_i;
                    data_mem[gi] <= b_data_i;
                end
            end
        end
    endgenerate

    always_comb begin
        wb_d      = 1'b0;
        wbr_num_d = '0;
        wb_data_d = '0;
        if (pop) begin
            wb_d      = 1'b1;
            wbr_num_d = rd_mem[rd_ptr_q];
            wb_data_d = data_mem[rd_ptr_q];
        end else if (a_req) begin
            wb_d      = 1'b1;
            wbr_num_d = a_rd_num_i;
            wb_data_d = a_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pend_d   = pend_q;
        if (store && !pop) begin
            pend_d = pend_q + 1'b1;
        end else if (pop && !store) begin
            pend_d = pend_q - 1'b1;
        end
        // The wait counter measures how long the current head has been passed over.
        cnt_d = cnt_q;
        if (!not_empty || pop) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            wb_q      <= 1'b0;
            wbr_num_q <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            wb_q      <= wb_d;
            wbr_num_q <= wbr_num_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage (requester A) and a long-latency functional unit such as a divider or an outstanding-load unit (requester B).
- B results are queued in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a B drain, stalling A for one cycle.
- Sits between the writeback stage / long-latency unit and the register file. All register-file write outputs are registered.

Parameters:
- WORD, 32, data width of a register write.
- W_RD, 5, register-number width.
- DEPTH, 2, B FIFO entries (power of two, >= 2).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may wait before a forced drain (>= 1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- a_v_i  in  1  A stage valid
- a_wb_i  in  1  A requests register write
- a_rd_num_i  in  W_RD  A destination register
- a_data_i  in  WORD  A write data
- a_stall_o  out  1  A must hold its inputs this cycle
- b_v_i  in  1  B result valid
- b_ready_o  out  1  B result accepted when b_v_i & b_ready_o
- b_rd_num_i  in  W_RD  B destination register
- b_data_i  in  WORD  B write data
- pend_o  out  clog2(DEPTH)+1  FIFO occupancy
- wb_o  out  1  register-file write enable
- wbr_num_o  out  W_RD  register-file write number
- wb_data_o  out  WORD  register-file write data

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset clears all of the following to 0: wb_o, wbr_num_o, wb_data_o, FIFO pointers, pend_o, starvation counter. Reset mid-operation discards all queued B entries.
- a_req = a_v_i & a_wb_i & (a_rd_num_i != 0). A write to x0 never uses the port.
- b_ready_o = (pend_o != DEPTH). It is a function of registered state only and does not depend on b_v_i.
- Push on b_v_i & b_ready_o. A B result with b_rd_num_i == 0 is accepted but not stored.
- Starvation counter `cnt`, width clog2(STARVE_MAX+1):
  - Cleared when the FIFO is empty or an entry pops.
  - Otherwise increments, saturating at STARVE_MAX.
- force = (pend_o != 0) & (cnt == STARVE_MAX).
- Grant priority per cycle, evaluated combinationally on current inputs and state:
  1. force: pop the FIFO head to the port. a_stall_o = a_v_i. A's write is not performed.
  2. else a_req: write A. a_stall_o = 0.
  3. else pend_o != 0: pop the FIFO head to the port.
  4. else: no write.
- a_stall_o is 0 in every case except case 1.
- Latency:
  - A grant appears on wb_o / wbr_num_o / wb_data_o exactly one cycle after the grant cycle.
  - A B result pushed in cycle t can pop no earlier than cycle t+1 (no bypass), so it is written at t+2 at the earliest.
- In a no-write cycle the registered outputs are wb_o = 0, wbr_num_o = 0, wb_data_o = 0.
- Simultaneous push and pop on a non-empty, non-full FIFO: pend_o is unchanged. Pointers wrap modulo DEPTH.
- Full FIFO: b_ready_o = 0. A pop in that cycle deasserts neither b_ready_o nor any other output combinationally; b_ready_o rises the next cycle.
- The FIFO is strictly in-order. No register-number ordering is enforced between A and B; dependency tracking belongs to the scoreboard.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while pend_o = 2 -> wb_o, wbr_num_o, wb_data_o and pend_o are 0 immediately; b_ready_o = 1 after release.
- A only: a_v_i = 1, a_wb_i = 1, a_rd_num_i = 3, a_data_i = 0xDEADBEEF -> next cycle wb_o = 1, wbr_num_o = 3, wb_data_o = 0xDEADBEEF. Repeat with a_rd_num_i = 0 -> wb_o = 0.
- Idle drain: push B (rd = 7, data = 0x12345678) at t with A idle -> wb_o = 1, wbr_num_o = 7, wb_data_o = 0x12345678 at t+2; pend_o back to 0 at t+2.
- Starvation: push one B entry, then hold a_req = 1 continuously with STARVE_MAX = 4 -> A is written for 4 cycles, then a_stall_o = 1 for exactly one cycle while the B entry is written, then A resumes with its held values.
- Full FIFO: with A writing every cycle and STARVE_MAX large, push 2 entries -> b_ready_o = 0 and a third b_v_i is not accepted; after the forced pop, b_ready_o = 1 on the following cycle.
- x0 drop: push a B entry with rd = 0 -> the push is accepted, pend_o stays unchanged, and no write is ever issued for it.
